axi4_stream_stat: RTL

AXI4_STREAM_STAT -- requirements
Module: axi4_stream_stat

---
 rtl/axi4_stream_stat_pkg.sv | 31 +++
 rtl/axi4_stream_if.sv | 19 +
 rtl/axi4_stream_popcnt.sv | 20 ++
 rtl/axi4_stream_stat.sv | 97 +++++++++
 4 files changed

// File: rtl/axi4_stream_stat_pkg.sv
// Shared constants and helpers for the AXI4-Stream statistics monitor.
// Saturating arithmetic is done at a fixed 64-bit working width; counter
// widths (CW, PW) up to 64 bits are supported.
package axi4_stream_stat_pkg;

  // Working width of the saturating adder; callers zero-extend into it.
  localparam int SAT_W = 64;

  // Reset/idle value of sts_min: all-ones, sliced down to CW by the user.
  localparam logic [SAT_W-1:0] STS_MIN_RST = '1;

  // Width needed to hold a TKEEP popcount without truncation (DN=4 -> 3).
  function automatic int inc_w(input int dn);
    return $clog2(dn + 1);
  endfunction

  // Add a+b and clamp to 2^w-1. Bit SAT_W of the result flags saturation,
  // bits [w-1:0] carry the clamped sum.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                             input logic [SAT_W-1:0] b,
                                             input int w);
    logic [SAT_W:0]   s;
    logic [SAT_W-1:0] lim;
    s = {1'b0, a} + {1'b0, b};
    if (w >= SAT_W) lim = '1;
    else            lim = (SAT_W'(1) << w) - SAT_W'(1);
    if (s > {1'b0, lim}) return {1'b1, lim};
    return {1'b0, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle carrying the handshake and byte-qualifier
// sideband needed by passive monitors; modport m observes only.
// transf marks a completed handshake (TVALID and TREADY both high).
interface axi4_stream_if #(
  parameter int DN = 1
) (
  input logic ACLK,
  input logic ARESETn
);
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
  logic [DN-1:0] TKEEP;
  logic          transf;

  assign transf = TVALID & TREADY;

  modport m (input ACLK, ARESETn, TVALID, TREADY, TLAST, TKEEP, transf);
endinterface

// File: rtl/axi4_stream_popcnt.sv
// Purpose: count set bits of TKEEP to get the byte increment of one beat.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module axi4_stream_popcnt
  import axi4_stream_stat_pkg::*;
#(
  parameter  int DN = 1,
  localparam int IW = inc_w(DN)
) (
  input  logic [DN-1:0] keep,
  output logic [IW-1:0] cnt
);

  // Ripple-sum every keep bit into an IW-wide count.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DN; i++) cnt = cnt + IW'(keep[i]);
  end

endmodule

// File: rtl/axi4_stream_stat.sv
// Purpose: passive per-packet byte statistics on an AXI4-Stream link.
// Latency: every statistic updates one cycle after the counted beat.
// Backpressure: none; monitors str only, beats dropped while frozen.
// Optional min/max tracking: define AXI4_STREAM_STAT_MINMAX_EN.
module axi4_stream_stat
  import axi4_stream_stat_pkg::*;
#(
  parameter int DN = 1,
  parameter int CW = 32,
  parameter int PW = 32
) (
  axi4_stream_if.m        str,
  input  logic            ctl_rst,
  input  logic            ctl_frz,
  output logic [CW-1:0]   sts_cur,
  output logic [CW-1:0]   sts_lst,
  output logic [PW-1:0]   sts_pkt,
  output logic [CW-1:0]   sts_min,
  output logic [CW-1:0]   sts_max,
  output logic            sts_ovf
);

  localparam int IW = inc_w(DN);

  logic [IW-1:0]  inc;
  logic           beat;
  logic [SAT_W:0] len_sum;
  logic [SAT_W:0] pkt_sum;
  logic [CW-1:0]  len;
  logic           len_sat;
  logic           pkt_sat;
  logic           sum_hi_unused;

  axi4_stream_popcnt #(.DN(DN)) u_popcnt (
    .keep (str.TKEEP),
    .cnt  (inc)
  );

  // A beat counts only on a handshake while not frozen; ctl_rst is
  // handled ahead of this in the register block so it always wins.
  assign beat = str.transf & ~ctl_frz;

  // Running length including this beat, and the next packet count.
  assign len_sum = sat_add(SAT_W'(sts_cur), SAT_W'(inc), CW);
  assign pkt_sum = sat_add(SAT_W'(sts_pkt), SAT_W'(1), PW);
  assign len     = len_sum[CW-1:0];
  assign len_sat = len_sum[SAT_W];
  assign pkt_sat = pkt_sum[SAT_W];

  // Bits above CW/PW are zero after clamping and are not needed.
  assign sum_hi_unused = ^{len_sum[SAT_W-1:0] >> CW, pkt_sum[SAT_W-1:0] >> PW};

  // Current/last length, packet count and sticky overflow.
  always_ff @(posedge str.ACLK or negedge str.ARESETn) begin
    if (!str.ARESETn) begin
      sts_cur <= '0;
      sts_lst <= '0;
      sts_pkt <= '0;
      sts_ovf <= 1'b0;
    end else if (ctl_rst) begin
      sts_cur <= '0;
      sts_lst <= '0;
      sts_pkt <= '0;
      sts_ovf <= 1'b0;
    end else if (beat) begin
      if (str.TLAST) begin
        sts_lst <= len;
        sts_cur <= '0;
        sts_pkt <= pkt_sum[PW-1:0];
        sts_ovf <= sts_ovf | len_sat | pkt_sat;
      end else begin
        sts_cur <= len;
        sts_ovf <= sts_ovf | len_sat;
      end
    end
  end

`ifdef AXI4_STREAM_STAT_MINMAX_EN
  // Shortest/longest completed packet, seeded so the first packet wins both.
  always_ff @(posedge str.ACLK or negedge str.ARESETn) begin
    if (!str.ARESETn) begin
      sts_min <= STS_MIN_RST[CW-1:0];
      sts_max <= '0;
    end else if (ctl_rst) begin
      sts_min <= STS_MIN_RST[CW-1:0];
      sts_max <= '0;
    end else if (beat && str.TLAST) begin
      if (len < sts_min) sts_min <= len;
      if (len > sts_max) sts_max <= len;
    end
  end
`else
  assign sts_min = STS_MIN_RST[CW-1:0];
  assign sts_max = '0;
`endif

endmodule
